// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - shared types and helpers for the deserializer word aligner
package ddr_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    CONFIRM,
    LOCKED
  } align_state_t;

  localparam logic [63:0] DEFAULT_TRAIN_WORD = 64'hA5A5_5A5A_F00F_0FF0;

  // Width of a counter spanning 0..s-1, never narrower than one bit.
  function automatic int phase_w(input int s);
    return (s > 1) ? $clog2(s) : 1;
  endfunction

endpackage

// File: rtl/word_aligner_if.sv
// rtl/word_aligner_if.sv - deserializer word in, framed word and lock status out
interface word_aligner_if #(
  parameter int D = 8,
  parameter int S = 8
);
  import ddr_pkg::*;

  localparam int W  = D * S;
  localparam int PW = phase_w(S);

  logic [W-1:0]  deser_word;
  logic          realign;
  logic [W-1:0]  aligned_data;
  logic          aligned_valid;
  logic          locked;
  logic [PW-1:0] phase_offset;
  logic          search_timeout;

  modport master (
    output deser_word, realign,
    input  aligned_data, aligned_valid, locked, phase_offset, search_timeout
  );

  modport slave (
    input  deser_word, realign,
    output aligned_data, aligned_valid, locked, phase_offset, search_timeout
  );

endinterface

// File: rtl/word_aligner.sv
// rtl/word_aligner.sv - finds the framing phase from a training word and emits one
// aligned word every S cycles once locked
module word_aligner
  import ddr_pkg::*;
#(
  parameter int             D              = 8,
  parameter int             S              = 8,
  parameter logic [D*S-1:0] TRAIN_WORD     = (D*S)'(DEFAULT_TRAIN_WORD),
  parameter int             LOCK_COUNT     = 4,
  parameter int             SEARCH_TIMEOUT = 1024
) (
  input logic           high_speed_clock,
  input logic           reset,
  word_aligner_if.slave bus
);

  localparam int PW = phase_w(S);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int TW = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;

  localparam logic [PW-1:0] PHASE_LAST = PW'(S - 1);
  localparam logic [MW-1:0] LOCK_LAST  = MW'(LOCK_COUNT);
  localparam logic [TW-1:0] TO_LAST    = TW'(SEARCH_TIMEOUT - 1);

  align_state_t    state;
  align_state_t    state_next;
  logic [PW-1:0]   phase_cnt;
  logic [PW-1:0]   phase_offset_r;
  logic [MW-1:0]   match_cnt;
  logic [TW-1:0]   timeout_cnt;
  logic [D*S-1:0]  aligned_data_r;
  logic            aligned_valid_r;
  logic            search_timeout_r;
  logic            match;
  logic            phase_hit;

  assign match     = (bus.deser_word == TRAIN_WORD);
  assign phase_hit = (phase_cnt == phase_offset_r);

  // Free-running and never touched by realign, so phases stay comparable across a relock.
  always_ff @(posedge high_speed_clock) begin
    if (reset) begin
      phase_cnt <= '0;
    end else if (phase_cnt == PHASE_LAST) begin
      phase_cnt <= '0;
    end else begin
      phase_cnt <= phase_cnt + PW'(1);
    end
  end

  always_ff @(posedge high_speed_clock) begin
    if (reset) begin
      state <= SEARCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (bus.realign) begin
      state_next = SEARCH;
    end else begin
      case (state)
        SEARCH: begin
          if (match) begin
            state_next = (LOCK_COUNT == 1) ? LOCKED : CONFIRM;
          end
        end
        CONFIRM: begin
          if (phase_hit) begin
            if (!match) begin
              state_next = SEARCH;
            end else if (match_cnt + MW'(1) == LOCK_LAST) begin
              state_next = LOCKED;
            end
          end
        end
        LOCKED:  state_next = LOCKED;
        default: state_next = SEARCH;
      endcase
    end
  end

  always_ff @(posedge high_speed_clock) begin
    if (reset) begin
      phase_offset_r   <= '0;
      match_cnt        <= '0;
      timeout_cnt      <= '0;
      aligned_data_r   <= '0;
      aligned_valid_r  <= 1'b0;
      search_timeout_r <= 1'b0;
    end else begin
      aligned_valid_r  <= 1'b0;
      search_timeout_r <= 1'b0;
      if (bus.realign) begin
        match_cnt   <= '0;
        timeout_cnt <= '0;
      end else begin
        case (state)
          SEARCH: begin
            if (match) begin
              phase_offset_r <= phase_cnt;
              match_cnt      <= MW'(1);
              timeout_cnt    <= '0;
            end else if (timeout_cnt == TO_LAST) begin
              timeout_cnt      <= '0;
              search_timeout_r <= 1'b1;
            end else begin
              timeout_cnt <= timeout_cnt + TW'(1);
            end
          end
          CONFIRM: begin
            if (phase_hit) begin
              if (match) begin
                match_cnt <= match_cnt + MW'(1);
              end else begin
                match_cnt   <= '0;
                timeout_cnt <= '0;
              end
            end
          end
          LOCKED: begin
            if (phase_hit) begin
              aligned_data_r  <= bus.deser_word;
              aligned_valid_r <= 1'b1;
            end
          end
          default: begin
            match_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign bus.aligned_data   = aligned_data_r;
  assign bus.aligned_valid  = aligned_valid_r;
  assign bus.locked         = (state == LOCKED);
  assign bus.phase_offset   = phase_offset_r;
  assign bus.search_timeout = search_timeout_r;

endmodule

// File: tb/tb_word_aligner.sv
// tb/tb_word_aligner.sv - randomized and directed checks of word_aligner against a
// behavioural model
module tb_word_aligner;

  localparam int S   = 8;
  localparam int LC  = 4;
  localparam int ST  = 16;
  localparam int S5  = 5;
  localparam int LC5 = 3;
  localparam logic [63:0] T8 = 64'hA5A5_5A5A_F00F_0FF0;
  localparam logic [39:0] T5 = 40'hC3_3CA5_5A96;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  word_aligner_if #(.D(8), .S(S))  ifc8 ();
  word_aligner_if #(.D(8), .S(S5)) ifc5 ();

  word_aligner #(
    .D(8), .S(S), .TRAIN_WORD(T8), .LOCK_COUNT(LC), .SEARCH_TIMEOUT(ST)
  ) dut8 (
    .high_speed_clock(clk), .reset(reset), .bus(ifc8)
  );

  word_aligner #(
    .D(8), .S(S5), .TRAIN_WORD(T5), .LOCK_COUNT(LC5), .SEARCH_TIMEOUT(1024)
  ) dut5 (
    .high_speed_clock(clk), .reset(reset), .bus(ifc5)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural model: time since reset gives the phase; mode 0/1/2 = hunting/confirming/locked.
  int          m_ticks, m_mode, m_off, m_hits, m_idle;
  logic [63:0] e_data;
  bit          e_valid, e_to;
  bit          m_live = 1'b0;

  always @(posedge clk) begin
    int ph;
    bit mt;
    if (reset) begin
      m_ticks = 0; m_mode = 0; m_off = 0; m_hits = 0; m_idle = 0;
      e_data = '0; e_valid = 1'b0; e_to = 1'b0;
      m_live = 1'b1;
    end else begin
      ph = m_ticks % S;
      mt = (ifc8.deser_word == T8);
      e_valid = 1'b0;
      e_to    = 1'b0;
      if (ifc8.realign) begin
        m_mode = 0; m_hits = 0; m_idle = 0;
      end else if (m_mode == 0) begin
        if (mt) begin
          m_off = ph; m_hits = 1; m_idle = 0;
          m_mode = (LC == 1) ? 2 : 1;
        end else if (m_idle == ST - 1) begin
          m_idle = 0; e_to = 1'b1;
        end else begin
          m_idle++;
        end
      end else if (m_mode == 1) begin
        if (ph == m_off) begin
          if (mt) begin
            m_hits++;
            if (m_hits == LC) m_mode = 2;
          end else begin
            m_mode = 0; m_hits = 0; m_idle = 0;
          end
        end
      end else if (ph == m_off) begin
        e_data  = ifc8.deser_word;
        e_valid = 1'b1;
      end
      m_ticks++;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      cmp("locked",         {63'd0, ifc8.locked},         {63'd0, m_mode == 2});
      cmp("aligned_valid",  {63'd0, ifc8.aligned_valid},  {63'd0, e_valid});
      cmp("aligned_data",   ifc8.aligned_data,            e_data);
      cmp("phase_offset",   64'(ifc8.phase_offset),       64'(m_off));
      cmp("search_timeout", {63'd0, ifc8.search_timeout}, {63'd0, e_to});
    end
  end

  function automatic logic [63:0] g8();
    logic [63:0] r;
    r = {$urandom, $urandom};
    if (r == T8) r[0] = ~r[0];
    return r;
  endfunction

  function automatic logic [39:0] g5();
    logic [39:0] r;
    r = {8'($urandom), $urandom};
    if (r == T5) r[0] = ~r[0];
    return r;
  endfunction

  task automatic tick(input logic [63:0] w8, input logic [39:0] w5, input bit rl);
    ifc8.deser_word = w8;
    ifc5.deser_word = w5;
    ifc8.realign    = rl;
    @(negedge clk);
  endtask

  task automatic reset_cycle();
    reset = 1'b1;
    tick(g8(), g5(), 1'b0);
    reset = 1'b0;
  endtask

  // Sends n training words at phase ph (match number bad is corrupted), garbage elsewhere.
  task automatic train(input int ph, input int n, input int bad);
    int sent  = 0;
    int guard = 0;
    while (sent < n && guard < (n + 2) * S) begin
      guard++;
      if (m_ticks % S == ph) begin
        sent++;
        tick((sent == bad) ? (T8 ^ 64'd1) : T8, g5(), 1'b0);
      end else begin
        tick(g8(), g5(), 1'b0);
      end
    end
    if (sent < n) begin
      miscompares++;
      $display("FAIL train_bound: sent %0d of %0d", sent, n);
    end
  endtask

  task automatic zero_checks(input string tag);
    cmp({tag, "_locked"},  {63'd0, ifc8.locked},         64'd0);
    cmp({tag, "_valid"},   {63'd0, ifc8.aligned_valid},  64'd0);
    cmp({tag, "_data"},    ifc8.aligned_data,            64'd0);
    cmp({tag, "_offset"},  64'(ifc8.phase_offset),       64'd0);
    cmp({tag, "_timeout"}, {63'd0, ifc8.search_timeout}, 64'd0);
  endtask

  initial begin
    logic [63:0] w;
    logic [63:0] held;
    logic [39:0] w5;
    int nv, np, p, last, sent, guard;
    bit rl, rs;

    ifc8.deser_word = '0;
    ifc8.realign    = 1'b0;
    ifc5.deser_word = '0;
    ifc5.realign    = 1'b0;
    held            = '0;
    reset           = 1'b1;
    @(negedge clk);
    @(negedge clk);
    zero_checks("reset");
    reset = 1'b0;

    // Clean lock at phase 3.
    train(3, 3, 0);
    cmp("clean_not_yet", {63'd0, ifc8.locked}, 64'd0);
    train(3, 1, 0);
    cmp("clean_locked", {63'd0, ifc8.locked}, 64'd1);
    cmp("clean_offset", 64'(ifc8.phase_offset), 64'd3);
    nv = 0;
    for (int k = 0; k < 24; k++) begin
      w = g8();
      tick(w, g5(), 1'b0);
      if (ifc8.aligned_valid) begin
        nv++;
        cmp("clean_data", ifc8.aligned_data, w);
        held = w;
      end
    end
    cmp("clean_valid_count", 64'(nv), 64'd3);

    // Realign mid-lock, relock at phase 1.
    tick(g8(), g5(), 1'b1);
    cmp("realign_locked", {63'd0, ifc8.locked}, 64'd0);
    cmp("realign_valid", {63'd0, ifc8.aligned_valid}, 64'd0);
    cmp("realign_hold", ifc8.aligned_data, held);
    train(1, 4, 0);
    cmp("relock1_locked", {63'd0, ifc8.locked}, 64'd1);
    cmp("relock1_offset", 64'(ifc8.phase_offset), 64'd1);

    // Broken confirm: third match corrupted, then clean lock at phase 6.
    tick(g8(), g5(), 1'b1);
    train(3, 3, 3);
    cmp("broken_locked", {63'd0, ifc8.locked}, 64'd0);
    for (int k = 0; k < 8; k++) tick(g8(), g5(), 1'b0);
    cmp("broken_still_unlocked", {63'd0, ifc8.locked}, 64'd0);
    train(6, 4, 0);
    cmp("relock6_locked", {63'd0, ifc8.locked}, 64'd1);
    cmp("relock6_offset", 64'(ifc8.phase_offset), 64'd6);

    // Reset mid-CONFIRM; afterwards the full match count is needed again.
    tick(g8(), g5(), 1'b1);
    train(2, 2, 0);
    reset_cycle();
    zero_checks("rst_confirm");
    train(2, 3, 0);
    cmp("rst_confirm_partial", {63'd0, ifc8.locked}, 64'd0);
    train(2, 1, 0);
    cmp("rst_confirm_relock", {63'd0, ifc8.locked}, 64'd1);
    cmp("rst_confirm_offset", 64'(ifc8.phase_offset), 64'd2);

    // Reset mid-LOCKED.
    for (int k = 0; k < 10; k++) tick(g8(), g5(), 1'b0);
    reset_cycle();
    zero_checks("rst_locked");

    // Timeout: no training word at all.
    np = 0;
    for (int k = 1; k <= 48; k++) begin
      tick(g8(), g5(), 1'b0);
      cmp("timeout_pulse", {63'd0, ifc8.search_timeout}, {63'd0, (k % 16) == 0});
      if (ifc8.search_timeout) np++;
      cmp("timeout_unlocked", {63'd0, ifc8.locked}, 64'd0);
    end
    cmp("timeout_pulses", 64'(np), 64'd3);

    // Random soak against the model.
    p = $urandom_range(0, S - 1);
    for (int k = 0; k < 3000; k++) begin
      rl = ($urandom_range(0, 149) == 0);
      rs = ($urandom_range(0, 399) == 0);
      if (m_ticks % S == p && $urandom_range(0, 3) != 0) begin
        w = ($urandom_range(0, 15) == 0) ? (T8 ^ 64'd1) : T8;
      end else if ($urandom_range(0, 49) == 0) begin
        w = T8;
      end else begin
        w = g8();
      end
      reset = rs;
      tick(w, g5(), rl);
      reset = 1'b0;
      if (rl || rs) p = $urandom_range(0, S - 1);
    end

    // Non-power-of-two ratio: S=5, phase 4.
    reset_cycle();
    sent  = 0;
    guard = 0;
    while (sent < LC5 && guard < (LC5 + 2) * S5) begin
      guard++;
      if (m_ticks % S5 == 4) begin
        sent++;
        tick(g8(), T5, 1'b0);
      end else begin
        tick(g8(), g5(), 1'b0);
      end
    end
    cmp("s5_train_sent", 64'(sent), 64'(LC5));
    cmp("s5_locked", {63'd0, ifc5.locked}, 64'd1);
    cmp("s5_offset", 64'(ifc5.phase_offset), 64'd4);
    nv   = 0;
    last = -1;
    for (int k = 0; k < 30; k++) begin
      w5 = g5();
      tick(g8(), w5, 1'b0);
      if (ifc5.aligned_valid) begin
        nv++;
        cmp("s5_data", 64'(ifc5.aligned_data), 64'(w5));
        cmp("s5_phase", 64'((m_ticks - 1) % S5), 64'd4);
        if (last >= 0) cmp("s5_spacing", 64'(k - last), 64'd5);
        last = k;
      end
    end
    cmp("s5_valid_count", 64'(nv), 64'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
